// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one of two write-back requesters (ALU, load unit) per
// cycle with round-robin on contention, drives a registered register-file write
// port, and keeps a pending-destination scoreboard that stalls decode.
// Optional feature: define WB_FWD_EN to report forwarding hits against the write
// committing this cycle and let those hits suppress the stall.
module wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rs_ad,
  input  logic [4:0]  rt_ad,
  output logic        stall,
  output logic        reg_write,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        fwd1_hit,
  output logic        fwd2_hit
);

  typedef enum logic {GntAlu = 1'b0, GntMem = 1'b1} grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic [31:0] busy_q, busy_d;

  // Combinational arbitration; the requester not served last wins a tie.
  always_comb begin
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    last_grant_d = last_grant_q;
    if (!reset) begin
      if (alu_valid && (!mem_valid || last_grant_q == GntMem)) begin
        alu_ready    = 1'b1;
        last_grant_d = GntAlu;
      end else if (mem_valid) begin
        mem_ready    = 1'b1;
        last_grant_d = GntMem;
      end
    end
  end

  // Scoreboard next state: clear on commit first so a same-edge issue wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write) begin
      busy_d[write_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != 5'd0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers: grant history, scoreboard and the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GntMem;
      busy_q       <= '0;
      reg_write    <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      reg_write    <= 1'b0;
      if (alu_ready) begin
        // Address 0 is accepted but never written.
        reg_write  <= (alu_addr != 5'd0);
        write_addr <= alu_addr;
        write_data <= alu_data;
      end else if (mem_ready) begin
        reg_write  <= (mem_addr != 5'd0);
        write_addr <= mem_addr;
        write_data <= mem_data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd1_hit = reg_write && (write_addr == rs_ad);
  assign fwd2_hit = reg_write && (write_addr == rt_ad);
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
`endif

  // A busy source stalls decode unless its value is being forwarded.
  always_comb begin
    stall = (busy_q[rs_ad] && !fwd1_hit) || (busy_q[rt_ad] && !fwd2_hit);
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (5-bit register address, 32-bit data, 32 registers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid / alu_ready  input / output  1 / 1  ALU write-back request and grant.
REQ-005 alu_addr / alu_data  input  5 / 32  ALU destination register and result.
REQ-006 mem_valid / mem_ready  input / output  1 / 1  load-unit write-back request and grant.
REQ-007 mem_addr / mem_data  input  5 / 32  load destination register and data.
REQ-008 issue_valid / issue_addr  input  1 / 5  decode marks a destination register as pending.
REQ-009 rs_ad / rt_ad  input  5 / 5  source registers of the instruction in decode.
REQ-010 stall  output  1  decode must hold; a source register is pending.
REQ-011 reg_write / write_addr / write_data  output  1 / 5 / 32  registered drive of the register-file write port.
REQ-012 fwd1_hit / fwd2_hit  output  1 / 1  rs / rt match the write committing this cycle.

Function
REQ-013 Grants are combinational: alu_ready and mem_ready reflect this cycle's arbitration; at most one is high per cycle.
REQ-014 Only one requester valid: grant it.
REQ-015 Both valid: grant the requester not granted most recently; last_grant updates only on a grant.
REQ-016 Neither valid: no grant; last_grant holds.
REQ-017 A requester keeps valid, addr and data stable until ready; a transfer occurs when valid and ready are both high.
REQ-018 Latency: a transfer in cycle N drives write_addr/write_data in cycle N+1.
REQ-019 reg_write in N+1 is high only if the transfer address is nonzero; address 0 is accepted (ready high) but never written.
REQ-020 No transfer in cycle N: reg_write low in N+1; write_addr and write_data hold their previous values.
REQ-021 Scoreboard busy[31:0]: issue_valid with nonzero issue_addr sets busy[issue_addr] at the next edge.
REQ-022 A cycle with reg_write high clears busy[write_addr] at the next edge.
REQ-023 Same-edge set and clear of one register: set wins.
REQ-024 busy[0] is constant 0; issue_addr = 0 is ignored.
REQ-025 stall = busy[rs_ad] OR busy[rt_ad], combinational from current busy state.
REQ-026 An issue to a register already busy leaves it busy; no count is kept.

Reset
REQ-027 While reset is high: reg_write = 0, write_addr = 0, write_data = 0, busy = 0, last_grant = mem, so the ALU wins the first contention.
REQ-028 While reset is high: alu_ready = mem_ready = 0; a request pending during reset is not transferred, and the requester re-presents it after reset.
REQ-029 A transfer accepted in the cycle reset asserts does not reach reg_write.

Configuration
REQ-030 Macro WB_FWD_EN is defined: fwd1_hit = reg_write AND (write_addr == rs_ad); fwd2_hit likewise for rt_ad.
REQ-031 WB_FWD_EN is defined: stall ignores a busy source whose fwd hit is high.
REQ-032 WB_FWD_EN is not defined: fwd1_hit and fwd2_hit are tied to 0, and stall follows REQ-025 only.

Verification
REQ-033 Reset, then alu_valid with addr 5 and data 0xDEADBEEF -> alu_ready high that cycle; next cycle reg_write = 1, write_addr = 5, write_data = 0xDEADBEEF.
REQ-034 Both requesters valid for 4 cycles (alu addr 3, mem addr 4), each re-presenting after a grant -> grants alternate alu, mem, alu, mem, starting with alu.
REQ-035 mem_valid with addr 0 and data 0x1234 -> mem_ready = 1; next cycle reg_write = 0; no busy change.
REQ-036 issue_addr 7, then rs_ad = 7 -> stall = 1; after an alu write to 7 commits -> stall = 0 the cycle after reg_write.
REQ-037 Same edge: issue 9 while write_addr 9 commits -> busy[9] stays 1 and stall stays 1 for rs_ad = 9.
REQ-038 With WB_FWD_EN defined: busy[6] set, rs_ad = 6, reg_write to 6 this cycle -> fwd1_hit = 1, stall = 0. Without the macro -> fwd1_hit = 0, stall = 1.
